l23buf_linectrl: RTL

Parametrised multi-line control unit for the L2/L3 buffer: one write FSM and one read FSM sharing a ring of 2^LINE_W buffer lines. Incoming AXI-Stream frames are written one line per frame; committed lines are replayed as a prepended header (from header memory) followed by the stored body. It drives the BRAM addresses and enables and the header/body output mux. It sits between the AXI ingress, the buffer and header BRAMs, and the AXI egress, and integrates in-block the line counters the previous single-line design kept external.

---
 rtl/l23buf_linectrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/l23buf_linectrl.sv
`default_nettype none
// l23buf_linectrl: write/read FSM pair over a ring of 2^LINE_W buffer lines with header prepend.
// Optional statistics counters are built when L23BUF_STATS_EN is defined.
module l23buf_linectrl #(
  parameter int ADDR_W  = 11,
  parameter int LINE_W  = 2,
  parameter int HDR_LEN = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_tvalid,
  input  logic                     s_tlast,
  input  logic                     s_tuser,
  output logic                     s_tready,
  output logic                     wr_en,
  output logic [LINE_W+ADDR_W-1:0] wr_addr,
  input  logic                     m_tready,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  output logic [LINE_W+ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0]        hdr_addr,
  output logic                     mux_sel,
  input  logic                     run_mgmt,
  output logic                     idle_mgmt,
  output logic [LINE_W:0]          lines_used,
  output logic [15:0]              frame_cnt,
  output logic [15:0]              drop_cnt
);
  localparam int                NLINES   = 1 << LINE_W;
  localparam logic [ADDR_W-1:0] CHAR_MAX = '1;
  localparam logic [ADDR_W-1:0] HDR_LAST = ADDR_W'(HDR_LEN - 1);
  localparam logic [LINE_W:0]   FULL     = (LINE_W+1)'(NLINES);

  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DROP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_HDR, R_BODY} rstate_e;

  wstate_e             wstate_q, wstate_d;
  rstate_e             rstate_q, rstate_d;
  logic [LINE_W-1:0]   wline_q, wline_d, rline_q, rline_d;
  logic [ADDR_W-1:0]   wchar_q, wchar_d, rchar_q, rchar_d, hchar_q, hchar_d;
  logic [ADDR_W-1:0]   len_q [NLINES];
  logic [LINE_W:0]     lines_used_q, lines_used_d;
  logic                m_tvalid_q, m_tlast_q, mux_sel_q;
  logic                tvalid_n, tlast_n, mux_n;
  logic                commit, drop_evt, free, body_last;

  // Write side: one frame per line; oversize frames fall into W_DROP until tlast.
  always_comb begin
    wstate_d = wstate_q;
    wline_d  = wline_q;
    wchar_d  = wchar_q;
    s_tready = 1'b0;
    wr_en    = 1'b0;
    commit   = 1'b0;
    drop_evt = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (lines_used_q < FULL) wstate_d = W_WRITE;
      end
      W_WRITE: begin
        s_tready = 1'b1;
        if (s_tvalid) begin
          if (!s_tlast) begin
            wchar_d = wchar_q + ADDR_W'(1);
            if (wchar_q == CHAR_MAX) wstate_d = W_DROP;
            else                     wr_en    = 1'b1;
          end else if (!s_tuser) begin
            wr_en    = 1'b1;
            commit   = 1'b1;
            wline_d  = wline_q + LINE_W'(1);
            wchar_d  = '0;
            wstate_d = W_IDLE;
          end else begin
            drop_evt = 1'b1;
            wchar_d  = '0;
            wstate_d = W_IDLE;
          end
        end
      end
      W_DROP: begin
        s_tready = 1'b1;
        if (s_tvalid && s_tlast) begin
          wchar_d  = '0;
          drop_evt = 1'b1;
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  assign body_last = (rchar_q == len_q[rline_q]);

  always_comb begin
    rstate_d = rstate_q;
    rline_d  = rline_q;
    rchar_d  = rchar_q;
    hchar_d  = hchar_q;
    free     = 1'b0;
    tvalid_n = 1'b0;
    tlast_n  = 1'b0;
    mux_n    = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if ((lines_used_q != '0) && run_mgmt) rstate_d = R_HDR;
      end
      R_HDR: begin
        tvalid_n = 1'b1;
        if (m_tready) begin
          if (hchar_q == HDR_LAST) begin
            hchar_d  = '0;
            rstate_d = R_BODY;
          end else begin
            hchar_d  = hchar_q + ADDR_W'(1);
          end
        end
      end
      R_BODY: begin
        tvalid_n = 1'b1;
        mux_n    = 1'b1;
        if (m_tready) begin
          if (body_last) begin
            tlast_n  = 1'b1;
            rchar_d  = '0;
            rline_d  = rline_q + LINE_W'(1);
            free     = 1'b1;
            rstate_d = R_IDLE;
          end else begin
            rchar_d  = rchar_q + ADDR_W'(1);
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    lines_used_d = lines_used_q;
    case ({commit, free})
      2'b10:   lines_used_d = lines_used_q + (LINE_W+1)'(1);
      2'b01:   lines_used_d = lines_used_q - (LINE_W+1)'(1);
      default: lines_used_d = lines_used_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q     <= W_IDLE;
      rstate_q     <= R_IDLE;
      wline_q      <= '0;
      wchar_q      <= '0;
      rline_q      <= '0;
      rchar_q      <= '0;
      hchar_q      <= '0;
      lines_used_q <= '0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      mux_sel_q    <= 1'b0;
      for (int i = 0; i < NLINES; i++) len_q[i] <= '0;
    end else begin
      wstate_q     <= wstate_d;
      rstate_q     <= rstate_d;
      wline_q      <= wline_d;
      wchar_q      <= wchar_d;
      rline_q      <= rline_d;
      rchar_q      <= rchar_d;
      hchar_q      <= hchar_d;
      lines_used_q <= lines_used_d;
      if (commit) len_q[wline_q] <= wchar_q;
      // Egress register tracks the address stage only on ready, matching BRAM latency.
      if (m_tready) begin
        m_tvalid_q <= tvalid_n;
        m_tlast_q  <= tlast_n;
        mux_sel_q  <= mux_n;
      end
    end
  end

`ifdef L23BUF_STATS_EN
  logic [15:0] frame_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (commit && (frame_cnt_q != 16'hFFFF))  frame_cnt_q <= frame_cnt_q + 16'd1;
      if (drop_evt && (drop_cnt_q != 16'hFFFF)) drop_cnt_q  <= drop_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`else
  logic stats_unused;
  assign stats_unused = drop_evt;
  assign frame_cnt    = '0;
  assign drop_cnt     = '0;
`endif

  assign wr_addr    = {wline_q, wchar_q};
  assign rd_addr    = {rline_q, rchar_q};
  assign hdr_addr   = hchar_q;
  assign m_tvalid   = m_tvalid_q;
  assign m_tlast    = m_tlast_q;
  assign mux_sel    = mux_sel_q;
  assign idle_mgmt  = (rstate_q == R_IDLE);
  assign lines_used = lines_used_q;

endmodule
`default_nettype wire
